// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit for the 32-bit bus datapath (fetch T0-T2, execute T3-T7).
// Optional MEM_WAIT_EN adds a Mem_ready input that stretches FETCH1, ld T6 and st T7 until memory responds.
module control_sequencer #(
    parameter int IR_W = 32,
    parameter int OP_W = 5,
    parameter int ST_W = 4
) (
    input  logic            Clock,
    input  logic            Reset_n,
    input  logic [IR_W-1:0] IR,
    input  logic            CON_FF,
    input  logic            Stop,
`ifdef MEM_WAIT_EN
    input  logic            Mem_ready,
`endif
    output logic            Gra,
    output logic            Grb,
    output logic            Grc,
    output logic            Rin,
    output logic            Rout,
    output logic            BAout,
    output logic            PCin,
    output logic            PCout,
    output logic            IncPC,
    output logic            MARin,
    output logic            MDRin,
    output logic            MDRout,
    output logic            IRin,
    output logic            Yin,
    output logic            Zin,
    output logic            ZLOout,
    output logic            Cout,
    output logic            CONin,
    output logic            Read,
    output logic            Write,
    output logic [OP_W-1:0] ALU_op,
    output logic            Run
);

    localparam logic [OP_W-1:0] OP_LD   = OP_W'(5'b00000);
    localparam logic [OP_W-1:0] OP_LDI  = OP_W'(5'b00001);
    localparam logic [OP_W-1:0] OP_ST   = OP_W'(5'b00010);
    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(5'b00011);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(5'b00100);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(5'b00101);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(5'b00110);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(5'b01100);
    localparam logic [OP_W-1:0] OP_ANDI = OP_W'(5'b01101);
    localparam logic [OP_W-1:0] OP_ORI  = OP_W'(5'b01110);
    localparam logic [OP_W-1:0] OP_NOT  = OP_W'(5'b10001);
    localparam logic [OP_W-1:0] OP_BR   = OP_W'(5'b10010);
    localparam logic [OP_W-1:0] OP_HALT = OP_W'(5'b11011);

    typedef enum logic [ST_W-1:0] {
        S_FETCH0, S_FETCH1, S_FETCH2, S_EXEC3, S_EXEC4, S_EXEC5, S_EXEC6, S_EXEC7, S_HALT
    } state_t;

    state_t          r_state;
    state_t          w_stateNext;
    state_t          w_lastState;
    logic            r_stopReq;
    logic            w_instEnd;
    logic            w_memReady;
    logic            w_memState;
    logic            w_advance;
    logic [OP_W-1:0] w_op;
    logic [OP_W-1:0] w_immOp;
    logic            w_unusedIr;
    logic            w_isAluReg, w_isAluImm, w_isNot, w_isLdi, w_isLd, w_isSt, w_isBr, w_isHalt;

    assign w_op       = IR[IR_W-1 -: OP_W];
    assign w_unusedIr = ^IR[IR_W-OP_W-1:0];

`ifdef MEM_WAIT_EN
    assign w_memReady = Mem_ready;
`else
    assign w_memReady = 1'b1;
`endif

    assign w_isAluReg = (w_op == OP_ADD) || (w_op == OP_SUB) || (w_op == OP_AND) || (w_op == OP_OR);
    assign w_isAluImm = (w_op == OP_ADDI) || (w_op == OP_ANDI) || (w_op == OP_ORI);
    assign w_isNot    = (w_op == OP_NOT);
    assign w_isLdi    = (w_op == OP_LDI);
    assign w_isLd     = (w_op == OP_LD);
    assign w_isSt     = (w_op == OP_ST);
    assign w_isBr     = (w_op == OP_BR);
    assign w_isHalt   = (w_op == OP_HALT);
    assign w_immOp    = (w_op == OP_ANDI) ? OP_AND : (w_op == OP_ORI) ? OP_OR : OP_ADD;

    // Final state of each instruction class; nop and undefined opcodes finish in FETCH2.
    always_comb begin
        w_lastState = S_FETCH2;
        if (w_isAluReg || w_isAluImm || w_isLdi) w_lastState = S_EXEC5;
        else if (w_isNot)                        w_lastState = S_EXEC4;
        else if (w_isLd || w_isSt)               w_lastState = S_EXEC7;
        else if (w_isBr)                         w_lastState = S_EXEC6;
    end

    assign w_memState = (r_state == S_FETCH1) || (r_state == S_EXEC6 && w_isLd) ||
                        (r_state == S_EXEC7 && w_isSt);
    assign w_advance  = !w_memState || w_memReady;

    always_comb begin
        w_stateNext = r_state;
        w_instEnd   = 1'b0;
        case (r_state)
            S_FETCH0: w_stateNext = S_FETCH1;
            S_HALT:   w_stateNext = S_HALT;
            default: begin
                if (w_advance) begin
                    if (r_state == S_FETCH2 && w_isHalt)
                        w_stateNext = S_HALT;
                    else if (r_state == w_lastState || r_state == S_EXEC7)
                        w_instEnd = 1'b1;
                    else
                        w_stateNext = state_t'(r_state + 1'b1);
                end
            end
        endcase
        if (w_instEnd)
            w_stateNext = (Stop || r_stopReq) ? S_HALT : S_FETCH0;
    end

    // A Stop seen anywhere inside an instruction is remembered until its last state.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state   <= S_FETCH0;
            r_stopReq <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            if (r_state != S_HALT && Stop)
                r_stopReq <= 1'b1;
        end
    end

    always_comb begin
        Gra = 1'b0;   Grb = 1'b0;    Grc = 1'b0;    Rin = 1'b0;    Rout = 1'b0;
        BAout = 1'b0; PCin = 1'b0;   PCout = 1'b0;  IncPC = 1'b0;  MARin = 1'b0;
        MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0;   Yin = 1'b0;    Zin = 1'b0;
        ZLOout = 1'b0; Cout = 1'b0;  CONin = 1'b0;  Read = 1'b0;   Write = 1'b0;
        ALU_op = OP_ADD;
        Run    = 1'b1;
        if (Reset_n) begin
            case (r_state)
                S_FETCH0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
                S_FETCH1: begin ZLOout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
                S_FETCH2: begin MDRout = 1'b1; IRin = 1'b1; end
                S_EXEC3: begin
                    if (w_isAluReg || w_isAluImm) begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    else if (w_isNot) begin Grb = 1'b1; Rout = 1'b1; ALU_op = OP_NOT; Zin = 1'b1; end
                    else if (w_isLdi || w_isLd || w_isSt) begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                    else if (w_isBr) begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                end
                S_EXEC4: begin
                    if (w_isAluReg) begin Grc = 1'b1; Rout = 1'b1; ALU_op = w_op; Zin = 1'b1; end
                    else if (w_isAluImm) begin Cout = 1'b1; ALU_op = w_immOp; Zin = 1'b1; end
                    else if (w_isLdi || w_isLd || w_isSt) begin Cout = 1'b1; Zin = 1'b1; end
                    else if (w_isNot) begin ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    else if (w_isBr) begin PCout = 1'b1; Yin = 1'b1; end
                end
                S_EXEC5: begin
                    if (w_isAluReg || w_isAluImm || w_isLdi) begin ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    else if (w_isLd || w_isSt) begin ZLOout = 1'b1; MARin = 1'b1; end
                    else if (w_isBr) begin Cout = 1'b1; Zin = 1'b1; end
                end
                S_EXEC6: begin
                    if (w_isLd) begin Read = 1'b1; MDRin = 1'b1; end
                    else if (w_isSt) begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                    else if (w_isBr) begin ZLOout = CON_FF; PCin = CON_FF; end
                end
                S_EXEC7: begin
                    if (w_isLd) begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    else if (w_isSt) Write = 1'b1;
                end
                S_HALT:  Run = 1'b0;
                default: ;
            endcase
        end
    end

endmodule
